mod_memarb: RTL and testbench

MOD_MEMARB -- requirements
Module: mod_memarb

---
 rtl/memarb_pkg.sv | 17 +
 rtl/mod_memarb_if.sv | 30 +++
 rtl/mod_memarb.sv | 100 ++++++++++
 tb/tb_mod_memarb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared definitions for the instruction/data memory arbiter and the RAM wrappers.
package memarb_pkg;

  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } grant_t;

endpackage

// File: rtl/mod_memarb_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter view, master the environment view.
interface mod_memarb_if #(
  parameter int unsigned ADDR_W = memarb_pkg::ADDR_W_DEF
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_rw;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mod_memarb.sv
// Two-port (instruction read / data read-write) arbiter onto one single-port RAM.
// Fixed 3-cycle access: sample in IDLE, drive RAM in ISSUE, ack in RESP.
module mod_memarb
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  mod_memarb_if.slave  bus
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        state, state_nx;
  grant_t        grant, grant_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic          sample;
  logic          rw_q;
  logic          resp_i, resp_d;

  // Only the word-address bits reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    starve_nx = starve_cnt;
    sample    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          sample   = 1'b1;
          state_nx = ST_ISSUE;
          if (bus.i_req && (!bus.d_req || starve_cnt == STARVE_LIM)) grant_nx = GNT_I;
          else                                                       grant_nx = GNT_D;
          // Counter only moves when the instruction port is actually waiting.
          if (grant_nx == GNT_I)
            starve_nx = '0;
          else if (bus.i_req && starve_cnt != STARVE_LIM)
            starve_nx = starve_cnt + 1'b1;
        end
      end
      ST_ISSUE: state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant      <= GNT_D;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      starve_cnt <= starve_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      rw_q        <= 1'b0;
    end else begin
      bus.m_en <= sample;
      bus.m_we <= 1'b0;
      if (sample) begin
        if (grant_nx == GNT_I) begin
          bus.m_addr <= bus.i_addr[ADDR_W+1:2];
          rw_q       <= 1'b0;
        end else begin
          bus.m_addr  <= bus.d_addr[ADDR_W+1:2];
          bus.m_wdata <= bus.d_wdata;
          bus.m_we    <= bus.d_rw;
          rw_q        <= bus.d_rw;
        end
      end
    end
  end

  // Acks decode straight from state so reset clears them without a clock.
  always_comb begin
    resp_i      = (state == ST_RESP) && (grant == GNT_I);
    resp_d      = (state == ST_RESP) && (grant == GNT_D);
    bus.i_ack   = resp_i;
    bus.d_ack   = resp_d;
    bus.i_rdata = resp_i ? bus.m_rdata : '0;
    bus.d_rdata = (resp_d && !rw_q) ? bus.m_rdata : '0;
  end

endmodule

// File: tb/tb_mod_memarb.sv
// Directed and randomized checks of mod_memarb against a transaction-level model.
module tb_mod_memarb;

  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_memarb_if #(.ADDR_W(9)) bus ();

  mod_memarb #(.ADDR_W(9), .STARVE_MAX(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram     [512];
  logic [31:0] ref_mem [512];

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata     <= ram[bus.m_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chkb({tag, "_iack"}, bus.i_ack, 1'b0);
    chkb({tag, "_dack"}, bus.d_ack, 1'b0);
    chk ({tag, "_irdata"}, bus.i_rdata, 32'h0);
    chk ({tag, "_drdata"}, bus.d_rdata, 32'h0);
    chkb({tag, "_men"}, bus.m_en, 1'b0);
    chkb({tag, "_mwe"}, bus.m_we, 1'b0);
    chk ({tag, "_maddr"}, 32'(bus.m_addr), 32'h0);
    chk ({tag, "_mwdata"}, bus.m_wdata, 32'h0);
  endtask

  typedef struct {
    bit          act;
    logic [31:0] addr;
    bit          rw;
    logic [31:0] data;
  } txn_t;

  initial begin
    logic [7:0]  gseq;
    int          nack, first_i, last_i;
    txn_t        ip, dp, cur;
    int          free_at, iss_at, ack_at, starve_m, waddr;
    bit          win_i;
    logic [31:0] exp_rd;

    for (int i = 0; i < 512; i++) begin
      ram[i]     = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = ram[i];
    end
    ram[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    chk("rst_starve", 32'(dut.starve_cnt), 32'h0);

    // Single instruction read; cycle 0 ends at the first edge after release
    @(negedge clk);
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    step();
    chkb("ird_men", bus.m_en, 1'b1);
    chkb("ird_mwe", bus.m_we, 1'b0);
    chk ("ird_maddr", 32'(bus.m_addr), 32'd5);
    chkb("ird_early_ack", bus.i_ack, 1'b0);
    step();
    chkb("ird_ack", bus.i_ack, 1'b1);
    chk ("ird_data", bus.i_rdata, 32'hDEAD_BEEF);
    chkb("ird_dack", bus.d_ack, 1'b0);
    bus.i_req = 1'b0;
    step();
    chkb("ird_ack_drop", bus.i_ack, 1'b0);
    chk ("ird_rdata_zero", bus.i_rdata, 32'h0);

    // Data write, then read of the same word with req held through the ack
    bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
    step();
    chkb("dwr_men", bus.m_en, 1'b1);
    chkb("dwr_mwe", bus.m_we, 1'b1);
    chk ("dwr_maddr", 32'(bus.m_addr), 32'd16);
    chk ("dwr_mwdata", bus.m_wdata, 32'h1234_5678);
    step();
    chkb("dwr_ack", bus.d_ack, 1'b1);
    chk ("dwr_rdata", bus.d_rdata, 32'h0);
    ref_mem[16] = 32'h1234_5678;
    bus.d_rw = 1'b0;
    step();
    chkb("drd_gap_men", bus.m_en, 1'b0);
    chkb("drd_gap_ack", bus.d_ack, 1'b0);
    step();
    chkb("drd_men", bus.m_en, 1'b1);
    chkb("drd_mwe", bus.m_we, 1'b0);
    chk ("drd_maddr", 32'(bus.m_addr), 32'd16);
    step();
    chkb("drd_ack", bus.d_ack, 1'b1);
    chk ("drd_data", bus.d_rdata, 32'h1234_5678);
    bus.d_req = 1'b0;
    step();

    // Address masking
    bus.i_req = 1'b1; bus.i_addr = 32'hFFFF_F803;
    step();
    chkb("mask_men", bus.m_en, 1'b1);
    chk ("mask_maddr", 32'(bus.m_addr), 32'h0);
    step();
    chkb("mask_ack", bus.i_ack, 1'b1);
    chk ("mask_data", bus.i_rdata, ref_mem[0]);
    bus.i_req = 1'b0;
    step();

    // Contention: D,D,D,I repeating, acks every 3 cycles
    gseq = 8'b1000_1000;
    nack = 0; first_i = -1; last_i = -1;
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h40;
    for (int c = 1; c <= 23; c++) begin
      step();
      if (c % 3 == 2) begin
        chkb("cont_iack", bus.i_ack, gseq[nack]);
        chkb("cont_dack", bus.d_ack, !gseq[nack]);
        if (gseq[nack]) begin
          chk("cont_idata", bus.i_rdata, 32'hDEAD_BEEF);
          if (first_i < 0) first_i = c; else last_i = c;
        end else begin
          chk("cont_ddata", bus.d_rdata, 32'h1234_5678);
        end
        nack++;
      end else begin
        chkb("cont_noack", bus.i_ack | bus.d_ack, 1'b0);
      end
    end
    chk("cont_i_period", 32'(last_i - first_i), 32'd12);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();

    // Reset during ISSUE of an instruction read
    bus.i_req = 1'b1; bus.i_addr = 32'h14;
    step();
    chkb("rsti_men", bus.m_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rsti");
    @(posedge clk);
    #1;
    chkb("rsti_hold_ack", bus.i_ack, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chkb("rsti_re_men", bus.m_en, 1'b1);
    chkb("rsti_re_early", bus.i_ack, 1'b0);
    step();
    chkb("rsti_re_ack", bus.i_ack, 1'b1);
    chk ("rsti_re_data", bus.i_rdata, 32'hDEAD_BEEF);
    bus.i_req = 1'b0;
    step();

    // Randomized traffic against the transaction model
    ip = '{default: 0};
    dp = '{default: 0};
    cur = '{default: 0};
    win_i = 1'b0; exp_rd = '0;
    free_at = 0; iss_at = -1; ack_at = -1; starve_m = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      chkb("rnd_men", bus.m_en, cyc == iss_at);
      if (cyc == iss_at) begin
        chkb("rnd_mwe", bus.m_we, !win_i && cur.rw);
        chk ("rnd_maddr", 32'(bus.m_addr), (cur.addr >> 2) & 32'h1FF);
        if (!win_i && cur.rw) chk("rnd_mwdata", bus.m_wdata, cur.data);
      end else begin
        chkb("rnd_mwe_idle", bus.m_we, 1'b0);
      end
      chkb("rnd_iack", bus.i_ack, cyc == ack_at && win_i);
      chkb("rnd_dack", bus.d_ack, cyc == ack_at && !win_i);
      chk ("rnd_irdata", bus.i_rdata, (cyc == ack_at && win_i) ? exp_rd : 32'h0);
      chk ("rnd_drdata", bus.d_rdata, (cyc == ack_at && !win_i && !cur.rw) ? exp_rd : 32'h0);
      if (cyc == ack_at) begin
        if (win_i) ip.act = 0; else dp.act = 0;
      end

      if (cyc < 300) begin
        if (!ip.act && $urandom_range(0, 2) != 0) begin
          ip.act = 1; ip.addr = $urandom; ip.rw = 0; ip.data = '0;
        end
        if (!dp.act && $urandom_range(0, 2) != 0) begin
          dp.act = 1; dp.addr = $urandom; dp.rw = 1'($urandom_range(0, 1)); dp.data = $urandom;
        end
      end
      bus.i_req   = ip.act;
      bus.i_addr  = ip.act ? ip.addr : $urandom;
      bus.d_req   = dp.act;
      bus.d_rw    = dp.rw;
      bus.d_addr  = dp.addr;
      bus.d_wdata = dp.data;

      if (cyc >= free_at && (ip.act || dp.act)) begin
        win_i = (ip.act && dp.act) ? (starve_m == STARVE) : ip.act;
        if (win_i) starve_m = 0;
        else if (ip.act && starve_m < STARVE) starve_m++;
        cur = win_i ? ip : dp;
        waddr = int'((cur.addr >> 2) & 32'h1FF);
        if (!win_i && cur.rw) begin
          ref_mem[waddr] = cur.data;
          exp_rd = '0;
        end else begin
          exp_rd = ref_mem[waddr];
        end
        iss_at = cyc + 1; ack_at = cyc + 2; free_at = cyc + 3;
      end
      step();
    end

    // Idle bus: nothing moves, starvation count retained
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chkb("idle_men", bus.m_en, 1'b0);
      chkb("idle_ack", bus.i_ack | bus.d_ack, 1'b0);
      chk ("idle_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
      step();
    end
    chk("idle_starve", 32'(dut.starve_cnt), 32'(starve_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
